// File: rtl/mem_port_arbiter.sv
// Arbitrates the I-side and D-side ports onto one single-ported memory, one transaction
// in flight, and routes each response back to the port that was granted.
module mem_port_arbiter #(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [AW-1:0]     i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DW-1:0]     i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [AW-1:0]     d_addr,
  input  logic [DW-1:0]     d_wdata,
  input  logic [DW/8-1:0]   d_be,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DW-1:0]     d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [AW-1:0]     m_addr,
  output logic [DW-1:0]     m_wdata,
  output logic [DW/8-1:0]   m_be,
  input  logic              m_rvalid,
  input  logic [DW-1:0]     m_rdata,
  output logic              err_spurious
);

  localparam int unsigned SW = $clog2(MAX_D_STREAK + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e          state_q;
  logic            owner_d_q;
  logic [SW-1:0]   streak_q;
  logic            m_req_q;
  logic            m_we_q;
  logic [AW-1:0]   m_addr_q;
  logic [DW-1:0]   m_wdata_q;
  logic [DW/8-1:0] m_be_q;
  logic            err_q;

  logic streak_full;
  logic i_win;
  logic d_win;
  logic idle;
  logic resp;

  assign streak_full = (streak_q == SW'(MAX_D_STREAK));
  assign i_win       = i_req && (!d_req || streak_full);
  assign d_win       = d_req && !i_win;
  assign idle        = (state_q == StIdle);

  // Grants are combinational; qualify with rst_n so nothing is granted while held in reset.
  assign i_gnt = rst_n && idle && i_win;
  assign d_gnt = rst_n && idle && d_win;

  assign resp     = (state_q == StWait) && m_rvalid;
  assign i_rvalid = resp && !owner_d_q;
  assign d_rvalid = resp && owner_d_q;
  assign i_rdata  = i_rvalid ? m_rdata : '0;
  assign d_rdata  = d_rvalid ? m_rdata : '0;

  assign m_req        = m_req_q;
  assign m_we         = m_we_q;
  assign m_addr       = m_addr_q;
  assign m_wdata      = m_wdata_q;
  assign m_be         = m_be_q;
  assign err_spurious = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      owner_d_q <= 1'b0;
      streak_q  <= '0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_be_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      m_req_q <= 1'b0;
      if (m_rvalid && (state_q != StWait)) begin
        err_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (!i_req) begin
            streak_q <= '0;
          end
          if (i_win) begin
            owner_d_q <= 1'b0;
            streak_q  <= '0;
            m_req_q   <= 1'b1;
            m_we_q    <= 1'b0;
            m_addr_q  <= i_addr;
            m_wdata_q <= '0;
            m_be_q    <= '1;
            state_q   <= StIssue;
          end else if (d_win) begin
            owner_d_q <= 1'b1;
            // Streak only counts D grants that actually made I wait.
            if (i_req && !streak_full) begin
              streak_q <= streak_q + 1'b1;
            end
            m_req_q   <= 1'b1;
            m_we_q    <= d_we;
            m_addr_q  <= d_addr;
            m_wdata_q <= d_wdata;
            m_be_q    <= d_be;
            state_q   <= StIssue;
          end
        end
        StIssue: state_q <= StWait;
        StWait: begin
          if (m_rvalid) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: grants, payload, response routing, starvation limit,
// spurious responses and mid-transaction reset, checked against a transaction scoreboard.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  logic        m_rvalid;
  logic [31:0] m_rdata;
  logic        err_spurious;

  mem_port_arbiter #(
    .AW           (32),
    .DW           (32),
    .MAX_D_STREAK (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req        (i_req),
    .i_addr       (i_addr),
    .i_gnt        (i_gnt),
    .i_rvalid     (i_rvalid),
    .i_rdata      (i_rdata),
    .d_req        (d_req),
    .d_we         (d_we),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_be         (d_be),
    .d_gnt        (d_gnt),
    .d_rvalid     (d_rvalid),
    .d_rdata      (d_rdata),
    .m_req        (m_req),
    .m_we         (m_we),
    .m_addr       (m_addr),
    .m_wdata      (m_wdata),
    .m_be         (m_be),
    .m_rvalid     (m_rvalid),
    .m_rdata      (m_rdata),
    .err_spurious (err_spurious)
  );

  typedef struct packed {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
  } txn_t;

  txn_t cmdq[$];
  txn_t rspq[$];
  int   checks   = 0;
  int   failures = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic txn_t mk(input logic is_d, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be,
                              input logic [31:0] rdata);
    txn_t t;
    t.is_d  = is_d;
    t.we    = we;
    t.addr  = addr;
    t.wdata = wdata;
    t.be    = be;
    t.rdata = rdata;
    return t;
  endfunction

  task automatic step();
    @(negedge clk);
    m_rvalid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".i_gnt"}, i_gnt, 0);
    chk({tag, ".i_rvalid"}, i_rvalid, 0);
    chk({tag, ".i_rdata"}, i_rdata, 0);
    chk({tag, ".d_gnt"}, d_gnt, 0);
    chk({tag, ".d_rvalid"}, d_rvalid, 0);
    chk({tag, ".d_rdata"}, d_rdata, 0);
    chk({tag, ".m_req"}, m_req, 0);
    chk({tag, ".m_we"}, m_we, 0);
    chk({tag, ".m_addr"}, m_addr, 0);
    chk({tag, ".m_wdata"}, m_wdata, 0);
    chk({tag, ".m_be"}, m_be, 0);
    chk({tag, ".err"}, err_spurious, 0);
  endtask

  task automatic check_grant(input string tag, input txn_t t);
    chk({tag, ".i_gnt"}, i_gnt, !t.is_d);
    chk({tag, ".d_gnt"}, d_gnt, t.is_d);
    cmdq.push_back(t);
  endtask

  task automatic check_issue(input string tag);
    txn_t t;
    chk({tag, ".m_req"}, m_req, 1);
    chk({tag, ".gnt_busy"}, {i_gnt, d_gnt}, 0);
    chk({tag, ".cmdq_nonempty"}, cmdq.size() != 0, 1);
    if (cmdq.size() != 0) begin
      t = cmdq.pop_front();
      chk({tag, ".m_we"}, m_we, t.we);
      chk({tag, ".m_addr"}, m_addr, t.addr);
      chk({tag, ".m_be"}, m_be, t.be);
      if (t.we) chk({tag, ".m_wdata"}, m_wdata, t.wdata);
      rspq.push_back(t);
    end
  endtask

  task automatic respond(input string tag);
    txn_t t;
    chk({tag, ".rspq_nonempty"}, rspq.size() != 0, 1);
    if (rspq.size() != 0) begin
      t = rspq.pop_front();
      m_rvalid = 1'b1;
      m_rdata  = t.rdata;
      #1;
      chk({tag, ".i_rvalid"}, i_rvalid, !t.is_d);
      chk({tag, ".d_rvalid"}, d_rvalid, t.is_d);
      chk({tag, ".gnt_busy"}, {i_gnt, d_gnt}, 0);
      if (t.is_d) begin
        chk({tag, ".i_rdata"}, i_rdata, 0);
        if (!t.we) chk({tag, ".d_rdata"}, d_rdata, t.rdata);
      end else begin
        chk({tag, ".i_rdata"}, i_rdata, t.rdata);
        chk({tag, ".d_rdata"}, d_rdata, 0);
      end
    end
  endtask

  initial begin
    txn_t t;
    int   streak;
    logic exp_d;

    rst_n    = 1'b0;
    i_req    = 1'b0;
    i_addr   = '0;
    d_req    = 1'b0;
    d_we     = 1'b0;
    d_addr   = '0;
    d_wdata  = '0;
    d_be     = '0;
    m_rvalid = 1'b0;
    m_rdata  = '0;

    // Reset held with random inputs
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      i_req    = 1'($urandom);
      i_addr   = $urandom;
      d_req    = 1'($urandom);
      d_we     = 1'($urandom);
      d_addr   = $urandom;
      d_wdata  = $urandom;
      d_be     = 4'($urandom);
      m_rvalid = 1'($urandom);
      m_rdata  = $urandom;
      #1;
      chk_all_zero("reset");
    end
    step();
    rst_n = 1'b1;
    i_req = 1'b0;
    d_req = 1'b0;
    d_be  = 4'h3;
    #1;
    chk("post_reset.err", err_spurious, 0);

    // Single I read, memory latency 2
    step();
    i_req  = 1'b1;
    i_addr = 32'h10;
    #1;
    check_grant("iread.gnt", mk(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF));
    step();
    i_req  = 1'b0;
    i_addr = $urandom;
    #1;
    check_issue("iread.issue");
    step();
    #1;
    chk("iread.wait.m_req", m_req, 0);
    chk("iread.wait.i_rvalid", i_rvalid, 0);
    step();
    respond("iread.rsp");

    // Conflict: D write wins, I follows
    step();
    i_req   = 1'b1;
    i_addr  = 32'h40;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h64;
    d_wdata = 32'd25;
    d_be    = 4'hF;
    #1;
    check_grant("conf.dgnt", mk(1'b1, 1'b1, 32'h64, 32'd25, 4'hF, $urandom));
    step();
    d_req  = 1'b0;
    d_addr = $urandom;
    #1;
    check_issue("conf.dissue");
    step();
    respond("conf.dack");
    step();
    #1;
    check_grant("conf.igant", mk(1'b0, 1'b0, 32'h40, 32'h0, 4'hF, $urandom));
    step();
    i_req = 1'b0;
    #1;
    check_issue("conf.iissue");
    step();
    respond("conf.irsp");

    // Starvation: both held, expect D x4, I, then D again
    streak = 0;
    i_req  = 1'b1;
    d_req  = 1'b1;
    d_we   = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      d_addr = 32'h200 + 32'(k * 4);
      d_be   = 4'h5;
      i_addr = 32'h300 + 32'(k * 4);
      #1;
      exp_d = (streak != 4);
      if (exp_d) begin
        t = mk(1'b1, 1'b0, d_addr, 32'h0, 4'h5, $urandom);
        streak = (streak < 4) ? streak + 1 : streak;
      end else begin
        t = mk(1'b0, 1'b0, i_addr, 32'h0, 4'hF, $urandom);
        streak = 0;
      end
      check_grant($sformatf("starve%0d.gnt", k), t);
      step();
      #1;
      check_issue($sformatf("starve%0d.issue", k));
      step();
      respond($sformatf("starve%0d.rsp", k));
    end
    step();
    i_req = 1'b0;
    d_req = 1'b0;
    #1;
    chk("pre_spur.err", err_spurious, 0);

    // Spurious response in IDLE
    step();
    m_rvalid = 1'b1;
    m_rdata  = 32'hCAFEF00D;
    #1;
    chk("spur.rvalid", {i_rvalid, d_rvalid}, 0);
    chk("spur.rdata", {i_rdata, d_rdata}, 0);
    step();
    #1;
    chk("spur.err_set", err_spurious, 1);
    repeat (3) step();
    #1;
    chk("spur.err_sticky", err_spurious, 1);

    // Reset during WAIT of a D read
    step();
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h80;
    d_be   = 4'hF;
    #1;
    check_grant("midrst.gnt", mk(1'b1, 1'b0, 32'h80, 32'h0, 4'hF, 32'h12345678));
    step();
    d_req = 1'b0;
    #1;
    check_issue("midrst.issue");
    step();
    #1;
    chk("midrst.wait.d_rvalid", d_rvalid, 0);
    step();
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst.assert");
    rspq.delete();
    step();
    #1;
    chk_all_zero("midrst.held");
    step();
    rst_n = 1'b1;
    #1;
    chk("midrst.release.err", err_spurious, 0);
    step();
    m_rvalid = 1'b1;
    m_rdata  = 32'h12345678;
    #1;
    chk("midrst.late.rvalid", {i_rvalid, d_rvalid}, 0);
    step();
    #1;
    chk("midrst.late.err", err_spurious, 1);

    // Recovery: I read with minimum latency
    step();
    i_req  = 1'b1;
    i_addr = 32'h44;
    #1;
    check_grant("recov.gnt", mk(1'b0, 1'b0, 32'h44, 32'h0, 4'hF, 32'hA5A55A5A));
    step();
    i_req = 1'b0;
    #1;
    check_issue("recov.issue");
    step();
    respond("recov.rsp");
    step();
    #1;
    chk("recov.idle", {i_rvalid, d_rvalid, m_req}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
